alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/branch ops plus
// iterative unsigned shift-add multiply and restoring divide.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       Instr_Type,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             Zero,
    output logic             err_div0,
    output logic             err_illegal
);

    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             accept;
    logic             last;

    logic             dec_mul;
    logic             dec_div;
    logic             dec_div0;
    logic             dec_ill;
    logic             dec_zero;
    logic [WIDTH-1:0] dec_res;
    logic [WIDTH-1:0] dec_hi;

    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_next;
    logic [WIDTH+1:0] div_diff;
    logic [AW-1:0]    div_next;
    logic [AW-1:0]    step;

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == MUL) || (state == DIV);
    assign done  = (state == DONE);
    assign last  = (cnt == CNT_W'(WIDTH - 1));

    // Decode straight from the inputs; only used on the accepting edge
    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_div0 = 1'b0;
        dec_ill  = 1'b0;
        dec_zero = 1'b0;
        dec_res  = '0;
        dec_hi   = '0;
        unique case (Instr_Type)
            2'b00: begin
                unique case (funct)
                    6'b100000: dec_res = readData1 + readData2;
                    6'b100010: dec_res = readData1 - readData2;
                    6'b100100: dec_res = readData1 & readData2;
                    6'b100101: dec_res = readData1 | readData2;
                    6'b101010: dec_res = {{(WIDTH-1){1'b0}},
                                          readData1 < readData2};
                    6'b011000: dec_mul = 1'b1;
                    6'b011010: begin
                        if (readData2 == '0) begin
                            dec_div0 = 1'b1;
                            dec_res  = '1;
                            dec_hi   = readData1;
                        end else begin
                            dec_div = 1'b1;
                        end
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            2'b01: begin
                unique case (funct)
                    6'b001000: dec_res = readData1 + readData2;
                    6'b001100: dec_res = readData1 & readData2;
                    6'b100011,
                    6'b101011: dec_res = readData1 + readData2;
                    6'b000100: begin
                        dec_res  = readData1 - readData2;
                        dec_zero = (readData1 == readData2);
                    end
                    6'b000101: begin
                        dec_res  = readData1 - readData2;
                        dec_zero = (readData1 != readData2);
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                if (funct == 6'b000010) dec_zero = 1'b1;
                else dec_ill = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // acc = {carry, hi, lo}; add A into the upper half, then shift right
    assign mul_sum  = acc[AW-1:WIDTH] + {1'b0, a_q};
    assign mul_next = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]}
                             : {1'b0, acc[AW-1:1]};

    // acc = {rem, quot}; shift left, trial-subtract B from remainder
    assign div_diff = {1'b0, acc[AW-2:WIDTH-1]} - {2'b00, b_q};
    assign div_next = div_diff[WIDTH+1]
                    ? {acc[AW-2:0], 1'b0}
                    : {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};

    assign step = (state == MUL) ? mul_next : div_next;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start) begin
                    accept = 1'b1;
                    if (dec_mul)      state_nx = MUL;
                    else if (dec_div) state_nx = DIV;
                    else              state_nx = DONE;
                end
            end
            MUL, DIV: begin
                if (last) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result      <= '0;
            hi          <= '0;
            Zero        <= 1'b0;
            err_div0    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q <= readData1;
                b_q <= readData2;
                cnt <= '0;
                if (dec_mul) acc <= {{(WIDTH+1){1'b0}}, readData2};
                else         acc <= {{(WIDTH+1){1'b0}}, readData1};
                if (!dec_mul && !dec_div) begin
                    result      <= dec_res;
                    hi          <= dec_hi;
                    Zero        <= dec_zero;
                    err_div0    <= dec_div0;
                    err_illegal <= dec_ill;
                end
            end else if (busy) begin
                acc <= step;
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    result      <= step[WIDTH-1:0];
                    hi          <= step[2*WIDTH-1:WIDTH];
                    Zero        <= 1'b0;
                    err_div0    <= 1'b0;
                    err_illegal <= 1'b0;
                end
            end
        end
    end

endmodule
